// File: rtl/cpu_phase_seq.sv
// Instruction-cycle phase sequencer: emits NUM_PHASES one-hot strobes spaced GAP clks
// apart every PERIOD clks, with run/single-step/stall control and a completed-cycle counter.
module cpu_phase_seq #(
  parameter int NUM_PHASES = 15,
  parameter int GAP        = 2,
  parameter int PERIOD     = 30,
  localparam int IDX_W     = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int TICK_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step_req,
  input  logic                  stall,
  output logic [NUM_PHASES-1:0] phase_strobe,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  cycle_done,
  output logic                  busy,
  output logic [15:0]           cycle_count
);

  if (NUM_PHASES < 1 || GAP < 1 || PERIOD < (NUM_PHASES - 1) * GAP + 1) begin : g_bad_params
    $error("cpu_phase_seq: illegal NUM_PHASES/GAP/PERIOD combination");
  end

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(PERIOD - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_nxt;
  logic [TICK_W-1:0]       tick, tick_nxt;
  logic                    single, single_nxt;
  logic [NUM_PHASES-1:0]   strobe_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    done_nxt, busy_nxt;
  logic [15:0]             count_nxt;

  function automatic logic [NUM_PHASES-1:0] strobe_at(input logic [TICK_W-1:0] t);
    logic [NUM_PHASES-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_PHASES; k++)
      if (int'(t) == k * GAP) s[k] = 1'b1;
    return s;
  endfunction

  // phase_idx follows the strobe that fires; held when none does
  function automatic logic [IDX_W-1:0] idx_of(input logic [NUM_PHASES-1:0] s,
                                               input logic [IDX_W-1:0] cur);
    logic [IDX_W-1:0] r;
    r = cur;
    for (int k = 0; k < NUM_PHASES; k++)
      if (s[k]) r = IDX_W'(k);
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick;
    single_nxt = single;
    strobe_nxt = '0;
    done_nxt   = 1'b0;
    busy_nxt   = busy;
    count_nxt  = cycle_count;
    case (state)
      IDLE: begin
        tick_nxt = '0;
        if (!stall && (run || step_req)) begin
          state_nxt  = ACTIVE;
          busy_nxt   = 1'b1;
          single_nxt = step_req & ~run;
          strobe_nxt = strobe_at('0);
          done_nxt   = (LAST_TICK == '0);
        end
      end
      ACTIVE: begin
        if (!stall) begin
          if (tick == LAST_TICK) begin
            count_nxt = cycle_count + 16'd1;
            tick_nxt  = '0;
            if (run && !single) begin
              strobe_nxt = strobe_at('0);
              done_nxt   = (LAST_TICK == '0);
            end else begin
              state_nxt  = IDLE;
              busy_nxt   = 1'b0;
              single_nxt = 1'b0;
            end
          end else begin
            tick_nxt   = tick + TICK_W'(1);
            strobe_nxt = strobe_at(tick_nxt);
            done_nxt   = (tick_nxt == LAST_TICK);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    idx_nxt = idx_of(strobe_nxt, phase_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick         <= '0;
      single       <= 1'b0;
      phase_strobe <= '0;
      phase_idx    <= '0;
      cycle_done   <= 1'b0;
      busy         <= 1'b0;
      cycle_count  <= '0;
    end else begin
      tick         <= tick_nxt;
      single       <= single_nxt;
      phase_strobe <= strobe_nxt;
      phase_idx    <= idx_nxt;
      cycle_done   <= done_nxt;
      busy         <= busy_nxt;
      cycle_count  <= count_nxt;
    end
  end

endmodule
